// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing decoder.
// Samples an external hsync/vsync pair on clk, advancing only on pix_ce. It recovers the pixel
// coordinates and the data-enable window, and confirms lock against the nominal timing.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   pix_ce       pixel-rate enable, one clk wide
//   hsync_in     asynchronous external hsync
//   vsync_in     asynchronous external vsync
//   x, y         active pixel column / line (hold outside the active window)
//   de           active pixel while locked
//   frame_start  one-clk pulse at pixel (0,0) of each locked frame
//   locked       timing confirmed
//   sync_err     one-clk pulse on any measured timing violation
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_TOTAL_W   = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W   = 11'(V_TOTAL);
  localparam logic [10:0] H_FIRST     = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_LAST      = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST     = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_LAST      = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [10:0] H_SAT       = 11'h7ff;
  localparam logic [9:0]  V_SAT       = 10'h3ff;
  localparam logic [3:0]  GOOD_TARGET = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  // Two-flop synchronizers, cleared to the deasserted level
  logic r_hs_meta, r_hs_sync, r_vs_meta, r_vs_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_meta <= ~SYNC_POL;
      r_hs_sync <= ~SYNC_POL;
      r_vs_meta <= ~SYNC_POL;
      r_vs_sync <= ~SYNC_POL;
    end else begin
      r_hs_meta <= hsync_in;
      r_hs_sync <= r_hs_meta;
      r_vs_meta <= vsync_in;
      r_vs_sync <= r_vs_meta;
    end
  end

  logic        r_hs_prev, r_vs_prev, r_vs_pend;
  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [3:0]  r_good;
  state_e      r_state;

  logic        w_hs_act, w_vs_act, w_line_start, w_vs_rise, w_v_align, w_vs_pend_nxt;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_h_sat, w_v_sat, w_line_bad, w_frame_bad, w_in_win;
  state_e      w_state_nxt;
  logic [3:0]  w_good_nxt;
  logic        w_err;

  assign w_hs_act     = (r_hs_sync == SYNC_POL);
  assign w_vs_act     = (r_vs_sync == SYNC_POL);
  assign w_line_start = w_hs_act & ~r_hs_prev;
  assign w_vs_rise    = w_vs_act & ~r_vs_prev;
  // A vsync edge anywhere in the previous line, or on this very sample, aligns this line start
  assign w_v_align    = w_line_start & (r_vs_pend | w_vs_rise);

  always_comb begin
    w_vs_pend_nxt = r_vs_pend;
    if (w_line_start) begin
      w_vs_pend_nxt = 1'b0;
    end else if (w_vs_rise) begin
      w_vs_pend_nxt = 1'b1;
    end
  end

  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_line_start) begin
      w_h_nxt = '0;
    end else if (r_h_cnt != H_SAT) begin
      w_h_nxt = r_h_cnt + 11'd1;
    end
    if (w_v_align) begin
      w_v_nxt = '0;
    end else if (w_line_start && (r_v_cnt != V_SAT)) begin
      w_v_nxt = r_v_cnt + 10'd1;
    end
  end

  // Saturation fires only on the step into the limit, so a stuck sync reports once
  assign w_h_sat     = !w_line_start && (r_h_cnt == H_SAT - 11'd1);
  assign w_v_sat     = w_line_start && !w_v_align && (r_v_cnt == V_SAT - 10'd1);
  assign w_line_bad  = w_line_start && (({1'b0, r_h_cnt} + 12'd1) != H_TOTAL_W);
  assign w_frame_bad = w_v_align && (({1'b0, r_v_cnt} + 11'd1) != V_TOTAL_W);

  assign w_in_win = (w_h_nxt >= H_FIRST) && (w_h_nxt <= H_LAST) &&
                    (w_v_nxt >= V_FIRST) && (w_v_nxt <= V_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err       = w_h_sat | w_v_sat;
    unique case (r_state)
      StSearch: begin
        if (w_v_align) begin
          w_state_nxt = StTrack;
          w_good_nxt  = '0;
        end
      end
      StTrack: begin
        if (w_h_sat || w_v_sat || w_line_bad || w_frame_bad) begin
          w_state_nxt = StSearch;
          w_good_nxt  = '0;
          w_err       = 1'b1;
        end else if (w_v_align) begin
          w_good_nxt = r_good + 4'd1;
          if (r_good + 4'd1 == GOOD_TARGET) begin
            w_state_nxt = StLocked;
          end
        end
      end
      StLocked: begin
        if (w_h_sat || w_v_sat || w_line_bad || w_frame_bad) begin
          w_state_nxt = StSearch;
          w_good_nxt  = '0;
          w_err       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StSearch;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_vs_pend <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_good    <= '0;
      r_state   <= StSearch;
      x         <= '0;
      y         <= '0;
      de        <= 1'b0;
      locked    <= 1'b0;
    end else if (pix_ce) begin
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;
      r_vs_pend <= w_vs_pend_nxt;
      r_h_cnt   <= w_h_nxt;
      r_v_cnt   <= w_v_nxt;
      r_good    <= w_good_nxt;
      r_state   <= w_state_nxt;
      if (w_in_win) begin
        x <= 10'(w_h_nxt - H_FIRST);
        y <= w_v_nxt - V_FIRST;
      end
      de     <= (w_state_nxt == StLocked) && w_in_win;
      locked <= (w_state_nxt == StLocked);
    end
  end

  // Pulse outputs last exactly one clk regardless of the pix_ce spacing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= pix_ce && (w_state_nxt == StLocked) && w_in_win &&
                     (w_h_nxt == H_FIRST) && (w_v_nxt == V_FIRST);
      sync_err    <= pix_ce && w_err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced timing (16 x 11) so whole frames
// stay short. Two instances run side by side: SYNC_POL=0 and SYNC_POL=1 with inverted syncs.
module tb_vga_sync_decoder;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int LF = 2;
  localparam int HT = HA + HF + HS + HB;  // 16
  localparam int VT = VA + VF + VS + VB;  // 11
  localparam int HST = HS + HB;           // first active column
  localparam int VST = VS + VB;           // first active line
  localparam int FRAME_DE = HA * VA;      // 48

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic       hs_pin[2];
  logic       vs_pin[2];
  logic [9:0] x_o[2];
  logic [9:0] y_o[2];
  logic       de_o[2], fs_o[2], lk_o[2], er_o[2];

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) u_dut0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync_in(hs_pin[0]), .vsync_in(vs_pin[0]),
    .x(x_o[0]), .y(y_o[0]), .de(de_o[0]), .frame_start(fs_o[0]),
    .locked(lk_o[0]), .sync_err(er_o[0])
  );

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .LOCK_FRAMES(LF)
  ) u_dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync_in(hs_pin[1]), .vsync_in(vs_pin[1]),
    .x(x_o[1]), .y(y_o[1]), .de(de_o[1]), .frame_start(fs_o[1]),
    .locked(lk_o[1]), .sync_err(er_o[1])
  );

  int tests = 0;
  int fails = 0;
  int de_cnt[2], fs_cnt[2], err_cnt[2], err_pix[2], xy_bad[2], fs_bad[2];
  int pix_num = 0;
  int last_h = 0;
  int last_v = 0;

  typedef struct {
    int nlines;
    int stretch;
    bit exp_lock;
    int exp_de;
    int exp_fs;
    int exp_err;
    int exp_err_at;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      de_cnt[d]  = 0;
      fs_cnt[d]  = 0;
      err_cnt[d] = 0;
      err_pix[d] = -1;
      xy_bad[d]  = 0;
      fs_bad[d]  = 0;
    end
  endtask

  // One pixel: drive syncs, run 4 clks with pix_ce on the last, sample outputs on negedges.
  // Outputs seen during this call belong to the previous pixel (last_h, last_v).
  task automatic pix(input bit hs_a, input bit vs_a, input int h, input int v);
    hs_pin[0] = ~hs_a;
    hs_pin[1] = hs_a;
    vs_pin[0] = ~vs_a;
    vs_pin[1] = vs_a;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pix_ce = (k == 3);
      for (int d = 0; d < 2; d++) begin
        if (er_o[d]) begin
          err_cnt[d]++;
          err_pix[d] = pix_num;
        end
        if (fs_o[d]) begin
          fs_cnt[d]++;
          if (!(x_o[d] == 10'd0 && y_o[d] == 10'd0 && de_o[d] && last_h == HST && last_v == VST))
            fs_bad[d]++;
        end
        if (pix_ce && de_o[d]) begin
          de_cnt[d]++;
          if (int'(x_o[d]) != last_h - HST || int'(y_o[d]) != last_v - VST) xy_bad[d]++;
        end
      end
    end
    last_h = h;
    last_v = v;
    pix_num++;
  endtask

  task automatic frame(input int nlines, input int stretch);
    int len;
    for (int v = 0; v < nlines; v++) begin
      len = (v == stretch) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) pix(h < HS, v < VS, h, v);
    end
  endtask

  task automatic frame_check(input string tag, input int nlines, input int stretch,
                             input bit exp_lock, input int exp_de, input int exp_fs,
                             input int exp_err, input int exp_err_at);
    int base;
    clear_counts();
    base = pix_num;
    frame(nlines, stretch);
    for (int d = 0; d < 2; d++) begin
      check({tag, ".locked"}, d, int'(lk_o[d]), int'(exp_lock));
      check({tag, ".de_count"}, d, de_cnt[d], exp_de);
      check({tag, ".frame_start_count"}, d, fs_cnt[d], exp_fs);
      check({tag, ".sync_err_count"}, d, err_cnt[d], exp_err);
      check({tag, ".xy_seq_errors"}, d, xy_bad[d], 0);
      check({tag, ".frame_start_pos_errors"}, d, fs_bad[d], 0);
      if (exp_err_at >= 0) check({tag, ".sync_err_pixel"}, d, err_pix[d] - base, exp_err_at);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish within 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    // nlines, stretch line, locked after, de, frame_start, sync_err, err pixel (-1 = none)
    vecs[0]  = '{VT, -1, 1'b0, 0,        0, 0, -1};  // first vsync: SEARCH -> TRACK
    vecs[1]  = '{VT, -1, 1'b0, 0,        0, 0, -1};  // good = 1
    vecs[2]  = '{VT, -1, 1'b1, FRAME_DE, 1, 0, -1};  // good = 2 at pixel 0: locked frame
    vecs[3]  = '{VT, -1, 1'b1, FRAME_DE, 1, 0, -1};
    vecs[4]  = '{VT,  6, 1'b0, 24,       1, 1, 114}; // line 6 is 17 pixels
    vecs[5]  = '{VT, -1, 1'b0, 0,        0, 0, -1};
    vecs[6]  = '{VT, -1, 1'b0, 0,        0, 0, -1};
    vecs[7]  = '{VT, -1, 1'b1, FRAME_DE, 1, 0, -1};
    vecs[8]  = '{VT + 1, -1, 1'b1, FRAME_DE, 1, 0, -1}; // 12-line frame, caught at next vsync
    vecs[9]  = '{VT, -1, 1'b0, 0,        0, 1, 1};
    vecs[10] = '{VT, -1, 1'b0, 0,        0, 0, -1};
    vecs[11] = '{VT, -1, 1'b0, 0,        0, 0, -1};
    vecs[12] = '{VT, -1, 1'b1, FRAME_DE, 1, 0, -1};

    reset     = 1'b1;
    pix_ce    = 1'b0;
    hs_pin[0] = 1'b1;
    hs_pin[1] = 1'b0;
    vs_pin[0] = 1'b1;
    vs_pin[1] = 1'b0;
    clear_counts();
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_outputs", d,
            int'({x_o[d], y_o[d], de_o[d], fs_o[d], lk_o[d], er_o[d]}), 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      frame_check($sformatf("vec%0d", i), vecs[i].nlines, vecs[i].stretch, vecs[i].exp_lock,
                  vecs[i].exp_de, vecs[i].exp_fs, vecs[i].exp_err, vecs[i].exp_err_at);

    // hsync stuck deasserted while locked: h_cnt walks 16..2047, one error only
    clear_counts();
    base = pix_num;
    for (int i = 0; i < 2240; i++) pix(1'b0, 1'b0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      check("hs_stuck.sync_err_count", d, err_cnt[d], 1);
      check("hs_stuck.sync_err_pixel", d, err_pix[d] - base, 2032);
      check("hs_stuck.locked", d, int'(lk_o[d]), 0);
      check("hs_stuck.de", d, int'(de_o[d]), 0);
    end
    frame_check("hs_relock_a", VT, -1, 1'b0, 0, 0, 0, -1);
    frame_check("hs_relock_b", VT, -1, 1'b0, 0, 0, 0, -1);
    frame_check("hs_relock_c", VT, -1, 1'b1, FRAME_DE, 1, 0, -1);

    // Reset in the middle of active line 6 while locked
    clear_counts();
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v == 6 && h == 8) begin
          for (int d = 0; d < 2; d++) begin
            check("pre_reset.locked", d, int'(lk_o[d]), 1);
            check("pre_reset.de", d, int'(de_o[d]), 1);
            check("pre_reset.x", d, int'(x_o[d]), 0);
            check("pre_reset.y", d, int'(y_o[d]), 2);
          end
          reset  = 1'b1;
          pix_ce = 1'b0;
          #1;
          for (int d = 0; d < 2; d++)
            check("async_reset_outputs", d,
                  int'({x_o[d], y_o[d], de_o[d], fs_o[d], lk_o[d], er_o[d]}), 0);
          repeat (3) @(negedge clk);
          reset = 1'b0;
        end
        pix(h < HS, v < VS, h, v);
      end
    end
    for (int d = 0; d < 2; d++) begin
      check("post_reset_frame.locked", d, int'(lk_o[d]), 0);
      check("post_reset_frame.sync_err_count", d, err_cnt[d], 0);
    end
    frame_check("rst_relock_a", VT, -1, 1'b0, 0, 0, 0, -1);
    frame_check("rst_relock_b", VT, -1, 1'b0, 0, 0, 0, -1);
    frame_check("rst_relock_c", VT, -1, 1'b1, FRAME_DE, 1, 0, -1);

    // pix_ce held low: sync noise must not move anything
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pix_ce    = 1'b0;
      hs_pin[0] = 1'($urandom_range(0, 1));
      hs_pin[1] = 1'($urandom_range(0, 1));
      vs_pin[0] = 1'($urandom_range(0, 1));
      vs_pin[1] = 1'($urandom_range(0, 1));
      for (int d = 0; d < 2; d++) if (er_o[d]) err_cnt[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      check("freeze.sync_err_count", d, err_cnt[d], 0);
      check("freeze.locked", d, int'(lk_o[d]), 1);
    end
    frame_check("after_freeze", VT, -1, 1'b1, FRAME_DE, 1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side VGA timing decoder. Samples an incoming hsync/vsync pair on the 100 MHz system clock, qualified by the same 25 MHz pixel-rate enable the pixel clock divider produces. Recovers pixel coordinates and the data-enable window, and confirms lock against the 640x480@60 timing the display path generates. Sits at the loopback/capture end of the VGA output path and feeds frame-capture and self-test logic.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of both sync inputs (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high; clock clk
- pix_ce  in  1  pixel-rate enable, one clk-cycle pulse every 4 clk
- hsync_in  in  1  asynchronous external hsync
- vsync_in  in  1  asynchronous external vsync
- x  out  10  active pixel column, 0..H_ACTIVE-1
- y  out  10  active line, 0..V_ACTIVE-1
- de  out  1  high while (x,y) is an active pixel and locked
- frame_start  out  1  one-clk pulse at the first active pixel (0,0) of each locked frame
- locked  out  1  timing confirmed
- sync_err  out  1  one-clk pulse on any measured timing violation

## Operation
- Both sync inputs pass through 2-flop synchronizers on clk. All logic below advances only on pix_ce = 1 cycles.
- hs_act = (hsync_s == SYNC_POL); vs_act likewise. Line start = hs_act rising (previous sample deasserted, current asserted).
- h_cnt (11 bit): 0 on line start, else +1, saturating at 2047. Line length check at each line start: h_cnt_prev+1 must equal H_TOTAL.
- vs_pend is set on the vs_act rising edge; cleared at next line start. v_cnt (10 bit): 0 at a line start with vs_pend set (or vs_act rising on the same sample), else +1 per line start, saturating at 1023. Frame length check at v_cnt reset: v_cnt_prev+1 must equal V_TOTAL.
- Active window: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]. x = h_cnt-(H_SYNC+H_BP), y = v_cnt-(V_SYNC+V_BP); x,y hold last value outside the window.
- FSM:
  - SEARCH: counters run, no checks. On first vsync-aligned line start -> TRACK, good=0.
  - TRACK: each completed frame with zero violations increments good; at good==LOCK_FRAMES -> LOCKED. Any violation -> SEARCH.
  - LOCKED: any violation -> SEARCH.
- Violations: wrong line length, wrong frame length, h_cnt reaching 2047 (hsync lost), v_cnt reaching 1023 (vsync lost). Each asserts sync_err for one clk. No violations are flagged in SEARCH except saturation.
- de and frame_start are gated by locked; x,y update in all states.

## Timing
- Reset: x=0, y=0, de=0, locked=0, frame_start=0, sync_err=0, FSM=SEARCH, h_cnt=0, v_cnt=0, good=0, synchronizers cleared to deasserted level. Reset mid-frame drops locked immediately; relock needs a new vsync plus LOCK_FRAMES frames.
- Input-to-decision latency: 2 clk synchronizer + up to 4 clk to next pix_ce.
- All outputs registered: state sampled on pix_ce cycle N appears at clk N+1 and holds until the next pix_ce update.
- locked rises at clk after the pix_ce completing frame LOCK_FRAMES. It falls at clk after the violating pix_ce, coincident with sync_err.
- A single violation line ends lock: no hysteresis.
- pix_ce held low: everything frozen, no watchdog progress.

## Test plan
- Clean 640x480@60 stream, SYNC_POL=0, pix_ce every 4 clk -> locked high after vsync + 2 frames; per locked frame exactly 307200 de cycles (pix_ce-qualified), first de at h_cnt=144, v_cnt=35 with x=0,y=0 and frame_start pulsed once.
- Locked stream, one line stretched to 801 pixels -> one sync_err pulse, locked low next clk, de low; relock after following vsync + 2 good frames.
- hsync stuck deasserted while locked -> h_cnt reaches 2047 -> sync_err, locked=0; no further sync_err while stuck.
- Frame of 526 lines -> sync_err at vsync, FSM to SEARCH, good reset to 0.
- Reset asserted at line 200 while locked -> all outputs 0 asynchronously; after release, locked only after next vsync + 2 frames.
- SYNC_POL=1 with inverted syncs -> identical de count and x/y sequence as scenario 1.
